spi_master_ctrl: RTL
====================

Name: spi_master_ctrl

Overview:
- SPI master byte-transaction controller, directly upstream of the MOSI PISO shift register; clocked by SCLK (5 MHz).
- Accepts a TX byte over valid/ready and drives the PISO load/shift_en/clear controls.
- Generates chip-select and the SCLK gate enable.
- Captures MISO into an internal SIPO and returns the RX byte with a one-cycle valid pulse.

Parameters:
- DATA_W, 8, transfer width in bits; must match the PISO width.
- CNT_W, $clog2(DATA_W), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  SCLK-domain clock, same net as the PISO clock.
- rst_n  input  1  asynchronous active-low reset.
- tx_data  input  DATA_W  byte to transmit.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  controller accepts tx_data this cycle.
- rx_data  output  DATA_W  last received byte; held until the next rx_valid.
- rx_valid  output  1  one-cycle pulse; rx_data updated.
- miso  input  1  serial data from slave, MSB first.
- piso_data  output  DATA_W  parallel byte to the PISO data_in.
- piso_load  output  1  PISO load strobe.
- piso_shift_en  output  1  PISO shift enable.
- piso_rst  output  1  active-high clear to the PISO.
- cs_n  output  1  slave select, active low.
- sclk_en  output  1  enables the external SCLK gate toward the slave.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, cs_n=1, piso_rst=1, piso_load=0, piso_shift_en=0, sclk_en=0, tx_ready=0, rx_valid=0, rx_data=0, piso_data=0, bit_cnt=0, busy=0.
- Output timing: all control outputs are flops, loaded from next-state decode, so they are glitch-free. piso_rst drives an async input and must never glitch.
- States:
  - IDLE: tx_ready=1, piso_rst=1, cs_n=1. On tx_valid&&tx_ready: latch tx_data into piso_data, go to LOAD.
  - LOAD (1 cycle): cs_n=0, piso_rst=0, piso_load=1, sclk_en=0. Go to SHIFT with bit_cnt=0.
  - SHIFT (DATA_W cycles): cs_n=0, piso_shift_en=1, sclk_en=1. The PISO MSB (tx bit DATA_W-1-bit_cnt) is on mosi. miso is sampled at the closing edge into the SIPO, MSB first. bit_cnt increments. When bit_cnt==DATA_W-1, go to DONE.
  - DONE (1 cycle): cs_n=1, sclk_en=0, rx_valid=1, rx_data=SIPO contents. Go to IDLE.
- Latency: handshake at cycle 0, then:
  - cs_n falls at cycle 1.
  - Bits occupy cycles 2..DATA_W+1.
  - rx_valid is asserted at cycle DATA_W+2.
  - IDLE is re-entered at DATA_W+3.
- Flow control:
  - tx_ready is 0 outside IDLE; tx_valid is ignored while busy.
  - rx_valid has no backpressure and is never repeated.
- bit_cnt is modulo DATA_W and only counts in SHIFT. No wrap is observable outside SHIFT.
- Final shift: the last SHIFT cycle still asserts piso_shift_en. The resulting zero shift-in is harmless because piso_rst reasserts in IDLE.
- Reset mid-transfer: immediate IDLE values, cs_n=1 asynchronously, no rx_valid, partial RX data discarded.
- tx_data changes while not accepted: no effect; piso_data is only loaded at the handshake.

Optional Feature:
- Macro: SPI_BURST_EN.
- Defined:
  - In the last SHIFT cycle (bit_cnt==DATA_W-1), tx_ready=1.
  - If tx_valid there, latch the byte and go to BURST_LOAD instead of DONE.
  - BURST_LOAD: rx_valid=1, rx_data updated, cs_n stays 0, piso_load=1, sclk_en=0 (the gap is suppressed on SCLK). Then SHIFT.
  - cs_n stays low for the whole burst; DONE is reached only when no byte is offered at the last bit.
- Undefined: tx_ready only in IDLE; every byte is framed by its own cs_n pulse; the BURST_LOAD state is absent.

Decomposition:
- spi_pkg holds:
  - the spi_state_e enum (IDLE, LOAD, SHIFT, DONE, BURST_LOAD);
  - the SPI_DATA_W=8 localparam default;
  - a helper constant for the counter width.
- Sub-module sipo_rx (clk, rst_n, sample_en, miso, data_out[DATA_W]): MSB-first shift-in, cleared on reset. Instantiated once inside spi_master_ctrl.

Test Plan:
- Reset then single byte: tx_data=8'hA5 with miso looped to mosi.
  - cs_n low for exactly 9 cycles (LOAD + 8 SHIFT).
  - mosi sequence 1,0,1,0,0,1,0,1.
  - rx_valid pulse with rx_data=8'hA5 at cycle 10.
- miso tied to 1, tx_data=8'h00: rx_data=8'hFF, mosi held 0 for all 8 bits, piso_shift_en high exactly 8 cycles.
- tx_valid held high with 8'h3C during a transfer: tx_ready=0 while busy; the second byte starts only after IDLE, with cs_n high at least 2 cycles between bytes.
- rst_n pulled low at bit 4 of 8'hF0: cs_n=1 and piso_rst=1 the same cycle, no rx_valid, next transfer of 8'h0F returns correct rx_data.
- SPI_BURST_EN with bytes 8'h11, 8'h22, 8'h33 back-to-back:
  - cs_n stays low across all 24 bit cycles plus 2 BURST_LOAD cycles.
  - sclk_en is 0 in each gap.
  - three rx_valid pulses.
- Without SPI_BURST_EN, same stimulus: three separate cs_n frames, tx_ready never asserted during SHIFT.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master byte controller.
// Consumed by spi_master_ctrl and sipo_rx; the burst option is SPI_BURST_EN.
package spi_pkg;

    localparam int SPI_DATA_W = 8;
    localparam int SPI_CNT_W  = $clog2(SPI_DATA_W);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD       = 3'd1,
        SHIFT      = 3'd2,
        DONE       = 3'd3,
        BURST_LOAD = 3'd4
    } spi_state_e;

endpackage

// File: rtl/sipo_rx.sv
// MISO capture register: shifts one bit per enabled cycle, MSB first.
// Cleared only by reset; a full byte always overwrites any earlier contents.
module sipo_rx
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_en,
    input  logic              miso,
    output logic [DATA_W-1:0] data_out
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
        end else if (sample_en) begin
            data_out <= {data_out[DATA_W-2:0], miso};
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master byte-transaction controller driving an external MOSI PISO.
// Define SPI_BURST_EN to chain bytes under one cs_n frame.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | cs_n high, PISO held clear, accepting a byte
// LOAD       | cs_n low, PISO parallel load, SCLK gated off
// SHIFT      | DATA_W bit cycles, SCLK running, MISO captured
// DONE       | cs_n high, rx_valid pulse
// BURST_LOAD | rx_valid pulse plus next-byte load, cs_n held low
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              miso,
    output logic [DATA_W-1:0] piso_data,
    output logic              piso_load,
    output logic              piso_shift_en,
    output logic              piso_rst,
    output logic              cs_n,
    output logic              sclk_en,
    output logic              busy
);

    localparam int                CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    spi_state_e        state;
    spi_state_e        state_nxt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  bit_cnt_nxt;
    logic [DATA_W-1:0] sipo_data;
    logic [DATA_W-1:0] rx_hold;
    logic              last_bit;
    logic              take_tx;

    logic cs_n_nxt;
    logic piso_rst_nxt;
    logic piso_load_nxt;
    logic shift_en_nxt;
    logic sclk_en_nxt;
    logic rx_valid_nxt;
    logic tx_ready_nxt;
    logic busy_nxt;

    assign last_bit = (state == SHIFT) && (bit_cnt == LAST_BIT);

`ifdef SPI_BURST_EN
    assign take_tx = tx_valid && tx_ready && ((state == IDLE) || last_bit);
`else
    assign take_tx = tx_valid && tx_ready && (state == IDLE);
`endif

    sipo_rx #(
        .DATA_W(DATA_W)
    ) u_sipo_rx (
        .clk      (clk),
        .rst_n    (rst_n),
        .sample_en(state == SHIFT),
        .miso     (miso),
        .data_out (sipo_data)
    );

    // The SIPO is complete and frozen while rx_valid is high, so it is shown
    // directly then; rx_hold keeps the byte afterwards while the SIPO refills.
    assign rx_data = rx_valid ? sipo_data : rx_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            cs_n          <= 1'b1;
            piso_rst      <= 1'b1;
            piso_load     <= 1'b0;
            piso_shift_en <= 1'b0;
            sclk_en       <= 1'b0;
            rx_valid      <= 1'b0;
            tx_ready      <= 1'b0;
            busy          <= 1'b0;
            piso_data     <= '0;
            rx_hold       <= '0;
        end else begin
            state         <= state_nxt;
            bit_cnt       <= bit_cnt_nxt;
            cs_n          <= cs_n_nxt;
            piso_rst      <= piso_rst_nxt;
            piso_load     <= piso_load_nxt;
            piso_shift_en <= shift_en_nxt;
            sclk_en       <= sclk_en_nxt;
            rx_valid      <= rx_valid_nxt;
            tx_ready      <= tx_ready_nxt;
            busy          <= busy_nxt;
            if (take_tx) begin
                piso_data <= tx_data;
            end
            if (rx_valid) begin
                rx_hold <= sipo_data;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (take_tx) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: state_nxt = SHIFT;
            SHIFT: begin
                if (last_bit) begin
`ifdef SPI_BURST_EN
                    state_nxt = take_tx ? BURST_LOAD : DONE;
`else
                    state_nxt = DONE;
`endif
                end
            end
            DONE: state_nxt = IDLE;
`ifdef SPI_BURST_EN
            BURST_LOAD: state_nxt = SHIFT;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so every
    // control line (notably the async piso_rst) comes straight from a flop.
    always_comb begin
        bit_cnt_nxt   = '0;
        if ((state == SHIFT) && (state_nxt == SHIFT)) begin
            bit_cnt_nxt = bit_cnt + 1'b1;
        end
        cs_n_nxt      = !((state_nxt == LOAD) || (state_nxt == SHIFT) ||
                          (state_nxt == BURST_LOAD));
        piso_rst_nxt  = (state_nxt == IDLE);
        piso_load_nxt = (state_nxt == LOAD) || (state_nxt == BURST_LOAD);
        shift_en_nxt  = (state_nxt == SHIFT);
        sclk_en_nxt   = (state_nxt == SHIFT);
        rx_valid_nxt  = (state_nxt == DONE) || (state_nxt == BURST_LOAD);
        busy_nxt      = (state_nxt != IDLE);
`ifdef SPI_BURST_EN
        tx_ready_nxt  = (state_nxt == IDLE) ||
                        ((state_nxt == SHIFT) && (bit_cnt_nxt == LAST_BIT));
`else
        tx_ready_nxt  = (state_nxt == IDLE);
`endif
    end

endmodule
